// File: rtl/_reduce_ratio.sv
// Divides both operands by the GCD stage's divisor using repeated subtraction.
// Flags a zero divisor or any non-zero remainder as an error.
module _reduce_ratio (
  input  logic       _clock,
  input  logic       _reset,
  input  logic [7:0] _num0,
  input  logic [7:0] _num1,
  input  logic [7:0] _greatest,
  input  logic       _success,
  input  logic       _out_ready,
  output logic [7:0] _quot0,
  output logic [7:0] _quot1,
  output logic       _valid,
  output logic       _busy,
  output logic       _error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] r0, r1, g, q0, q1;
  logic       success_q;
  logic       capture;
  logic       ge0, ge1;

  assign capture = _success & ~success_q;
  assign ge0     = (r0 >= g);
  assign ge1     = (r1 >= g);
  assign _busy   = (state == DIV);
  assign _valid  = (state == DONE);

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state     <= IDLE;
      success_q <= 1'b0;
      r0        <= '0;
      r1        <= '0;
      g         <= '0;
      q0        <= '0;
      q1        <= '0;
      _quot0    <= '0;
      _quot1    <= '0;
      _error    <= 1'b0;
    end else begin
      success_q <= _success;
      unique case (state)
        IDLE: begin
          if (capture) begin
            r0    <= _num0;
            r1    <= _num1;
            g     <= _greatest;
            q0    <= '0;
            q1    <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (g == 8'd0) begin
            _quot0 <= '0;
            _quot1 <= '0;
            _error <= 1'b1;
            state  <= DONE;
          end else if (!ge0 && !ge1) begin
            _quot0 <= q0;
            _quot1 <= q1;
            _error <= (r0 != 8'd0) | (r1 != 8'd0);
            state  <= DONE;
          end else begin
            // Lanes step independently; a finished lane just idles.
            if (ge0) begin
              r0 <= r0 - g;
              q0 <= q0 + 8'd1;
            end
            if (ge1) begin
              r1 <= r1 - g;
              q1 <= q1 + 8'd1;
            end
          end
        end
        DONE: begin
          if (_out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb__reduce_ratio.sv
// Scoreboard bench for _reduce_ratio: directed operand sets,
// expected quotients queued at issue and checked by a monitor.
module tb__reduce_ratio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num0 = '0, num1 = '0, greatest = '0;
  logic       success = 1'b0, out_ready = 1'b0;
  logic [7:0] quot0, quot1;
  logic       valid, busy, error;

  int n_chk = 0;
  int n_fail = 0;
  logic [16:0] sb [$];
  logic vq = 1'b0;

  always #5 clk = ~clk;

  _reduce_ratio dut (
    ._clock(clk), ._reset(rst),
    ._num0(num0), ._num1(num1), ._greatest(greatest),
    ._success(success), ._out_ready(out_ready),
    ._quot0(quot0), ._quot1(quot1),
    ._valid(valid), ._busy(busy), ._error(error)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (valid && !vq) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quot0", int'(quot0), int'(e[16:9]));
        chk("quot1", int'(quot1), int'(e[8:1]));
        chk("error", int'(error), int'(e[0]));
      end
    end
    vq = valid;
  end

  task automatic wait_done(input int lat);
    int n = 0;
    int busy_ok = 1;
    while (!valid && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (!valid && !busy) busy_ok = 0;
    end
    chk("latency", n, lat);
    chk("busy_in_div", busy_ok, 1);
    chk("busy_in_done", int'(busy), 0);
  endtask

  task automatic accept(input int hold, input logic [7:0] e0, e1);
    int held = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!valid || quot0 !== e0 || quot1 !== e1) held = 0;
    end
    if (hold > 0) chk("held_outputs", held, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_after_accept", int'(valid), 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic op(input logic [7:0] a, b, g, e0, e1,
                    input logic ee, input int lat,
                    input int hold, input logic keep);
    @(negedge clk);
    num0 = a;
    num1 = b;
    greatest = g;
    success = 1'b1;
    sb.push_back({e0, e1, ee});
    @(posedge clk);
    wait_done(lat);
    accept(hold, e0, e1);
    if (keep) begin
      repeat (5) @(posedge clk);
      #1;
      chk("no_retrigger", int'(busy | valid), 0);
    end
    @(negedge clk);
    success = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_quot0", int'(quot0), 0);
    chk("rst_quot1", int'(quot1), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'd12, 8'd18, 8'd6, 8'd2, 8'd3, 1'b0, 4, 0, 1'b0);
    op(8'd7, 8'd9, 8'd0, 8'd0, 8'd0, 1'b1, 1, 0, 1'b0);
    op(8'd255, 8'd1, 8'd1, 8'd255, 8'd1, 1'b0, 256, 0, 1'b0);
    op(8'd12, 8'd18, 8'd4, 8'd3, 8'd4, 1'b1, 5, 0, 1'b0);
    op(8'd0, 8'd5, 8'd5, 8'd0, 8'd1, 1'b0, 2, 0, 1'b0);
    op(8'd12, 8'd18, 8'd6, 8'd2, 8'd3, 1'b0, 4, 10, 1'b1);

    // Reset mid-division: outputs clear at once, no result follows.
    num0 = 8'd12;
    num1 = 8'd18;
    greatest = 8'd6;
    success = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_quot0", int'(quot0), 0);
    chk("arst_quot1", int'(quot1), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_error", int'(error), 0);
    @(negedge clk);
    success = 1'b0;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_after_arst", int'(busy | valid), 0);

    // Success already high at reset release counts as a capture.
    @(negedge clk);
    rst = 1'b1;
    num0 = 8'd12;
    num1 = 8'd18;
    greatest = 8'd6;
    success = 1'b1;
    sb.push_back({8'd2, 8'd3, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    wait_done(4);
    accept(0, 8'd2, 8'd3);
    @(negedge clk);
    success = 1'b0;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
